// File: rtl/video_pkg.sv
// Shared types and constants for the video scan sequencer: FSM state encoding,
// handshake origin, position width and the default panel geometry.
package video_pkg;

  localparam int POS_W        = 10;
  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_PIXELS = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CURSOR,
    ST_SETTLE,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_ADVANCE
  } scan_state_e;

  // Which strobe a busy handshake belongs to; selects the retry target and the
  // state that follows the handshake.
  typedef enum logic {
    ORG_CURSOR,
    ORG_STROBE
  } origin_e;

endpackage

// File: rtl/video_scan_sequencer_if.sv
// Bundle between the scan sequencer and its surroundings (LCD driver handshake,
// CPU scroll registers, datapath position). master = sequencer side.
interface video_scan_sequencer_if
  import video_pkg::*;
#(
  parameter int FCNT_W = 16
);

  logic              enable;
  logic              busy;
  logic [8:0]        cfg_xofs;
  logic [8:0]        cfg_yofs;
  logic [POS_W-1:0]  xpos;
  logic [POS_W-1:0]  ypos;
  logic [8:0]        xofs;
  logic [8:0]        yofs;
  logic              pix_clk;
  logic              reset_cursor;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_count;
  logic              ack_err;

  modport master (
    input  enable, busy, cfg_xofs, cfg_yofs,
    output xpos, ypos, xofs, yofs, pix_clk, reset_cursor, frame_done, frame_count, ack_err
  );

  modport slave (
    output enable, busy, cfg_xofs, cfg_yofs,
    input  xpos, ypos, xofs, yofs, pix_clk, reset_cursor, frame_done, frame_count, ack_err
  );

endinterface

// File: rtl/scan_counter.sv
// Column-major x/y scan position: ypos is the inner index. Advancing from the
// last pixel wraps to the origin; clear has priority over advance.
module scan_counter
  import video_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_PIXELS = DEF_V_PIXELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [POS_W-1:0] xpos_o,
  output logic [POS_W-1:0] ypos_o,
  output logic             last_o
);

  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic             y_last;

  assign y_last = (y_q == POS_W'(V_PIXELS - 1));
  assign last_o = y_last && (x_q == POS_W'(H_PIXELS - 1));

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (!y_last) begin
        y_d = y_q + 1'b1;
      end else begin
        y_d = '0;
        x_d = last_o ? '0 : x_q + 1'b1;
      end
    end
  end

  // NOTE: state is written with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign xpos_o = x_q;
  assign ypos_o = y_q;

endmodule

// File: rtl/video_scan_sequencer.sv
// Single-clock scan FSM driving the pixel datapath and the ILI9341 driver handshakes.
// Build option: define SCAN_SHADOW_EN to latch the scroll offsets at each frame start.
module video_scan_sequencer
  import video_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_PIXELS    = DEF_V_PIXELS,
  parameter int PIPE_LAT    = 2,
  parameter int ACK_TIMEOUT = 15,
  parameter int FCNT_W      = 16
) (
  input logic                    clk,
  input logic                    reset,
  video_scan_sequencer_if.master bus
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  scan_state_e       state_q, state_d;
  origin_e           origin_q, origin_d;
  logic              frame_end_q, frame_end_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;
  logic              ack_err_q, ack_err_d;
  logic              pix_clk_q, reset_cursor_q, frame_done_q;
  logic              cnt_adv, cnt_clr, cnt_last;

  scan_counter #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_scan_counter (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (cnt_clr),
    .advance_i (cnt_adv),
    .xpos_o    (bus.xpos),
    .ypos_o    (bus.ypos),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    origin_d      = origin_q;
    frame_end_d   = frame_end_q;
    settle_cnt_d  = '0;
    ack_cnt_d     = '0;
    frame_count_d = frame_count_q;
    ack_err_d     = ack_err_q;
    cnt_adv       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_CURSOR;
      end
      ST_CURSOR: begin
        origin_d = ORG_CURSOR;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = (origin_q == ORG_CURSOR) ? ST_CURSOR : ST_STROBE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.busy) begin
          if (origin_q == ORG_CURSOR) begin
            state_d = ST_SETTLE;
          end else begin
            // The position moves as ADVANCE is entered, giving the datapath the
            // ADVANCE cycle plus PIPE_LAT settle cycles before the next strobe.
            state_d     = ST_ADVANCE;
            cnt_adv     = 1'b1;
            frame_end_d = cnt_last;
            if (cnt_last) frame_count_d = frame_count_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 4'(PIPE_LAT - 1)) state_d = ST_STROBE;
        else                                  settle_cnt_d = settle_cnt_q + 1'b1;
      end
      ST_STROBE: begin
        origin_d = ORG_STROBE;
        state_d  = ST_WAIT_ACK;
      end
      ST_ADVANCE: begin
        if (!bus.enable)     state_d = ST_IDLE;
        else if (frame_end_q) state_d = ST_CURSOR;
        else                  state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An aborted frame restarts from the origin.
    cnt_clr = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      origin_q       <= ORG_CURSOR;
      frame_end_q    <= 1'b0;
      settle_cnt_q   <= '0;
      ack_cnt_q      <= '0;
      frame_count_q  <= '0;
      ack_err_q      <= 1'b0;
      pix_clk_q      <= 1'b0;
      reset_cursor_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      origin_q       <= origin_d;
      frame_end_q    <= frame_end_d;
      settle_cnt_q   <= settle_cnt_d;
      ack_cnt_q      <= ack_cnt_d;
      frame_count_q  <= frame_count_d;
      ack_err_q      <= ack_err_d;
      pix_clk_q      <= (state_d == ST_STROBE);
      reset_cursor_q <= (state_d == ST_CURSOR);
      frame_done_q   <= (state_d == ST_ADVANCE) && frame_end_d;
    end
  end

  assign bus.pix_clk      = pix_clk_q;
  assign bus.reset_cursor = reset_cursor_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.ack_err      = ack_err_q;

`ifdef SCAN_SHADOW_EN
  logic [8:0] xofs_q, yofs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xofs_q <= '0;
      yofs_q <= '0;
    end else if (state_d == ST_CURSOR) begin
      xofs_q <= bus.cfg_xofs;
      yofs_q <= bus.cfg_yofs;
    end
  end

  assign bus.xofs = xofs_q;
  assign bus.yofs = yofs_q;
`else
  assign bus.xofs = bus.cfg_xofs;
  assign bus.yofs = bus.cfg_yofs;
`endif

endmodule

// File: tb/tb_video_scan_sequencer.sv
// Scoreboard bench for video_scan_sequencer on a reduced 6x8 frame with a 3-bit
// frame counter; expected strobes are queued as the LCD side answers each one.
module tb_video_scan_sequencer;
  import video_pkg::*;

  localparam int H_PIX    = 6;
  localparam int V_PIX    = 8;
  localparam int PIPE_LAT = 2;
  localparam int ACK_TO   = 15;
  localparam int FCNT_W   = 3;
  localparam int WAIT_MAX = 200;

  typedef struct packed {
    logic       cur;
    logic [9:0] x;
    logic [9:0] y;
  } strobe_t;

  logic clk;
  logic reset;

  video_scan_sequencer_if #(.FCNT_W(FCNT_W)) vif ();

  video_scan_sequencer #(
    .H_PIXELS    (H_PIX),
    .V_PIXELS    (V_PIX),
    .PIPE_LAT    (PIPE_LAT),
    .ACK_TIMEOUT (ACK_TO),
    .FCNT_W      (FCNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  strobe_t exp_q[$];
  int      n_checks = 0;
  int      n_err    = 0;
  int      done_seen = 0;
  int      done_exp  = 0;
  int      strobe_seen = 0;
  int      fc = 0;
  logic [8:0] cfg_x, cfg_y;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  task automatic tick();
    @(negedge clk);
    if (vif.frame_done) done_seen++;
    if (vif.pix_clk || vif.reset_cursor) strobe_seen++;
  endtask

  // Waits for the next strobe and scores it against the head of the queue.
  task automatic wait_strobe(output int waited, output strobe_t got);
    strobe_t e;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(vif.pix_clk || vif.reset_cursor) && waited < WAIT_MAX);
    got = '{cur: vif.reset_cursor, x: vif.xpos, y: vif.ypos};
    if (!(vif.pix_clk || vif.reset_cursor)) begin
      check("strobe_seen", 32'(vif.pix_clk | vif.reset_cursor), 32'd1);
      finish_run();
    end
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("strobe_kind", {30'd0, vif.reset_cursor, vif.pix_clk}, e.cur ? 32'd2 : 32'd1);
      check("xpos", 32'(vif.xpos), 32'(e.x));
      check("ypos", 32'(vif.ypos), 32'(e.y));
      if (e.cur) begin
        check("frame_done_cnt", 32'(done_seen), 32'(done_exp));
        check("frame_count", 32'(vif.frame_count), 32'(fc % (1 << FCNT_W)));
        check("xofs_at_cursor", 32'(vif.xofs), 32'(cfg_x));
        check("yofs_at_cursor", 32'(vif.yofs), 32'(cfg_y));
      end
    end
  endtask

  // LCD side: busy rises on the strobe and stays high for len cycles.
  task automatic respond(input int len);
    vif.busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 0) check("strobe_one_cycle", {30'd0, vif.reset_cursor, vif.pix_clk}, 32'd0);
    end
    vif.busy = 1'b0;
  endtask

  task automatic push_next(input strobe_t s);
    strobe_t n;
    if (s.cur) begin
      n = '{cur: 1'b0, x: 10'd0, y: 10'd0};
    end else if (int'(s.y) < V_PIX - 1) begin
      n = '{cur: 1'b0, x: s.x, y: s.y + 10'd1};
    end else if (int'(s.x) < H_PIX - 1) begin
      n = '{cur: 1'b0, x: s.x + 10'd1, y: 10'd0};
    end else begin
      done_exp++;
      fc++;
      n = '{cur: 1'b1, x: 10'd0, y: 10'd0};
    end
    exp_q.push_back(n);
  endtask

  task automatic do_strobe();
    int      w;
    strobe_t s;
    wait_strobe(w, s);
    respond(int'($urandom_range(4, 2)));
    push_next(s);
  endtask

  // No busy answer: ack_err after ACK_TO idle cycles and the same pixel is re-strobed.
  task automatic timeout_strobe();
    int      w, base;
    strobe_t s, s2;
    wait_strobe(w, s);
    base = strobe_seen;
    repeat (ACK_TO) tick();
    check("ack_err_before_to", 32'(vif.ack_err), 32'd0);
    check("no_strobe_in_to", 32'(strobe_seen), 32'(base));
    exp_q.push_back(s);
    wait_strobe(w, s2);
    check("restrobe_cycle", 32'(w), 32'd1);
    check("ack_err_after_to", 32'(vif.ack_err), 32'd1);
    respond(2);
    push_next(s2);
  endtask

  // enable drops while the driver is finishing the pixel: no frame_done, back to origin.
  task automatic abort_strobe();
    int      w, base_s, base_d;
    strobe_t s;
    wait_strobe(w, s);
    vif.busy = 1'b1;
    tick();
    tick();
    vif.enable = 1'b0;
    vif.busy   = 1'b0;
    base_s = strobe_seen;
    base_d = done_seen;
    repeat (8) tick();
    check("abort_xpos", 32'(vif.xpos), 32'd0);
    check("abort_ypos", 32'(vif.ypos), 32'd0);
    check("abort_no_strobe", 32'(strobe_seen), 32'(base_s));
    check("abort_no_done", 32'(done_seen), 32'(base_d));
    check("abort_fcount", 32'(vif.frame_count), 32'(fc % (1 << FCNT_W)));
    vif.enable = 1'b1;
    exp_q.push_back('{cur: 1'b1, x: 10'd0, y: 10'd0});
  endtask

  initial begin
    int      w;
    strobe_t s;
    logic [8:0] old_x;

    reset        = 1'b1;
    vif.enable   = 1'b0;
    vif.busy     = 1'b0;
    cfg_x        = 9'h0AA;
    cfg_y        = 9'h055;
    vif.cfg_xofs = cfg_x;
    vif.cfg_yofs = cfg_y;
    repeat (3) @(negedge clk);

    check("rst_xpos", 32'(vif.xpos), 32'd0);
    check("rst_ypos", 32'(vif.ypos), 32'd0);
    check("rst_pix_clk", 32'(vif.pix_clk), 32'd0);
    check("rst_reset_cursor", 32'(vif.reset_cursor), 32'd0);
    check("rst_frame_done", 32'(vif.frame_done), 32'd0);
    check("rst_frame_count", 32'(vif.frame_count), 32'd0);
    check("rst_ack_err", 32'(vif.ack_err), 32'd0);
`ifdef SCAN_SHADOW_EN
    check("rst_xofs", 32'(vif.xofs), 32'd0);
    check("rst_yofs", 32'(vif.yofs), 32'd0);
`else
    check("rst_xofs", 32'(vif.xofs), 32'(cfg_x));
    check("rst_yofs", 32'(vif.yofs), 32'(cfg_y));
`endif

    vif.enable = 1'b1;
    tick();
    check("rc_held_in_reset", 32'(vif.reset_cursor), 32'd0);
    exp_q.push_back('{cur: 1'b1, x: 10'd0, y: 10'd0});
    reset = 1'b0;

    // Cursor one cycle after release, then the first pixel PIPE_LAT+1 cycles after busy falls.
    wait_strobe(w, s);
    check("first_cursor_cycle", 32'(w), 32'd1);
    respond(2);
    push_next(s);
    wait_strobe(w, s);
    check("settle_latency", 32'(w), 32'(PIPE_LAT + 1));
    respond(2);
    push_next(s);

    for (int k = 1; k < H_PIX * V_PIX; k++) begin
      if (k == 10) begin
        old_x        = vif.xofs;
        cfg_x        = 9'h005;
        cfg_y        = 9'h123;
        vif.cfg_xofs = cfg_x;
        vif.cfg_yofs = cfg_y;
        #1;
`ifdef SCAN_SHADOW_EN
        check("shadow_hold_x", 32'(vif.xofs), 32'(old_x));
`else
        check("direct_x", 32'(vif.xofs), 32'(cfg_x));
        check("direct_y", 32'(vif.yofs), 32'(cfg_y));
`endif
        tick();
`ifdef SCAN_SHADOW_EN
        check("shadow_hold_x2", 32'(vif.xofs), 32'(old_x));
`else
        check("direct_x2", 32'(vif.xofs), 32'(cfg_x));
`endif
      end
      if (k == 17) timeout_strobe();
      else         do_strobe();
    end

    // Eight more frames: the 3-bit frame counter wraps back to 0.
    repeat (8 * (H_PIX * V_PIX + 1)) do_strobe();
    check("fc_model_wrapped", 32'(fc), 32'd9);

    while (!(exp_q.size() == 1 && exp_q[0].cur == 1'b0 &&
             exp_q[0].x == 10'd3 && exp_q[0].y == 10'd4)) begin
      do_strobe();
    end
    abort_strobe();

    repeat (5) do_strobe();
    check("ack_err_sticky", 32'(vif.ack_err), 32'd1);
    check("final_fcount", 32'(vif.frame_count), 32'(fc % (1 << FCNT_W)));
    check("final_done_cnt", 32'(done_seen), 32'(done_exp));

    finish_run();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_scan_sequencer.md
Name: video_scan_sequencer

Overview:
Synchronous scan controller that sequences the video pixel datapath (tile, texture and sprite lookup) into the ILI9341 LCD driver. It replaces edge-triggered, busy-clocked position logic with a single-clock FSM. The FSM generates the scan position, waits out memory read latency, and runs the pix_clk/busy and reset_cursor/busy handshakes. It also reports frame completion and holds the scroll offsets steady for the whole of each frame.

Parameters:
H_PIXELS, 320, columns per frame (xpos range 0..H_PIXELS-1)
V_PIXELS, 240, rows per column (ypos range 0..V_PIXELS-1)
PIPE_LAT, 2, cycles from a position change to valid pixel data at the datapath output (range 1..15)
ACK_TIMEOUT, 15, cycles to wait for busy to rise before re-strobing
FCNT_W, 16, frame counter width

Ports:
clk  in  1  system clock; the LCD driver runs on the same clock
reset  in  1  asynchronous reset, active-high
enable  in  1  level; scan runs while high
busy  in  1  LCD driver busy; synchronous to clk
cfg_xofs  in  9  CPU x scroll register
cfg_yofs  in  9  CPU y scroll register
xpos  out  10  current column
ypos  out  10  current row
xofs  out  9  scroll x offset applied to the datapath
yofs  out  9  scroll y offset applied to the datapath
pix_clk  out  1  one-cycle pixel strobe to the LCD driver
reset_cursor  out  1  one-cycle cursor-home strobe to the LCD driver
frame_done  out  1  one-cycle pulse when the last pixel completes
frame_count  out  FCNT_W  number of completed frames; wraps
ack_err  out  1  sticky flag: a handshake timed out

Behaviour:
- Reset: every output is 0; FSM is in IDLE; internal counters are 0. Reset asserted mid-operation aborts immediately with no partial strobe.
- Scan order is column-major: ypos is the inner index, xpos the outer. Advance rule:
  - ypos < V_PIXELS-1: ypos+1.
  - Otherwise: ypos=0 and xpos+1.
  - At the last pixel (H_PIXELS-1, V_PIXELS-1): the frame ends.
- FSM states: IDLE, CURSOR, SETTLE, STROBE, WAIT_ACK, WAIT_DONE, ADVANCE. All outputs are registered and decoded from state.
- IDLE: xpos=ypos=0. If enable is high, go to CURSOR.
- CURSOR: reset_cursor=1 for exactly one cycle, then WAIT_ACK with origin=CURSOR.
- WAIT_ACK:
  - busy=1: go to WAIT_DONE.
  - ACK_TIMEOUT cycles with busy=0: set ack_err and return to the origin state to re-strobe.
  - busy already high on entry counts as ack.
- WAIT_DONE: when busy=0, go to SETTLE if origin=CURSOR, otherwise ADVANCE.
- SETTLE: hold for PIPE_LAT cycles, then go to STROBE. A position change therefore always precedes pix_clk by at least PIPE_LAT+1 cycles.
- STROBE: pix_clk=1 for exactly one cycle, then WAIT_ACK with origin=STROBE.
- ADVANCE:
  - Last pixel: frame_done=1 for one cycle, frame_count+1 (wraps at 2^FCNT_W), xpos=ypos=0, next state CURSOR if enable is high, else IDLE.
  - Not the last pixel: update the position, next state SETTLE if enable is high, else IDLE.
- enable falling mid-pixel: the current handshake completes. ADVANCE then goes to IDLE and the position returns to 0. Re-enable always starts a fresh frame with CURSOR. No frame_done is issued for an aborted frame.
- busy toggling outside WAIT_ACK/WAIT_DONE is ignored.
- ack_err is cleared only by reset.

Optional Feature:
SCAN_SHADOW_EN.
- Defined: xofs/yofs are shadow registers loaded from cfg_xofs/cfg_yofs only on entry to CURSOR, so CPU scroll writes take effect at frame start and cannot tear a frame. Both shadows are 0 after reset.
- Undefined: xofs=cfg_xofs and yofs=cfg_yofs combinationally, with immediate effect.

Decomposition:
- Package video_pkg: FSM state enum; default geometry constants H_PIXELS/V_PIXELS; the position width constant (10).
- Sub-module scan_counter: the x/y position counter with advance, clear and last-pixel flag. The FSM stays in video_scan_sequencer.

Test Plan:
1. reset=1 → all outputs 0. Release with enable=1 → reset_cursor high for one cycle at cycle 2. With busy responding 1 cycle high → pix_clk at (0,0) exactly PIPE_LAT+1 cycles after busy falls.
2. Pixel at (0,239) with busy handshake → next position (1,0). Pixel at (0,5) → (0,6).
3. Complete pixel (319,239) → frame_done for one cycle, frame_count 0→1, position (0,0), reset_cursor strobe follows. Force frame_count to 0xFFFF → wraps to 0.
4. busy held 0 after a pix_clk → ack_err set after 15 cycles, pix_clk re-strobed at the same position. Then busy responds → scan continues; ack_err stays 1.
5. enable dropped during WAIT_DONE at (10,20) → handshake finishes, IDLE, position (0,0), no frame_done. Re-enable → reset_cursor first.
6. SCAN_SHADOW_EN defined, cfg_xofs written 0x05 mid-frame → xofs unchanged until the next CURSOR, then 0x05. Undefined → xofs follows in the same cycle.
